// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable frame width, all four CPOL/CPHA modes,
// runtime clock divider and one-hot chip selects; one frame per accepted start.
module spi_master_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CS     = 1,
    parameter int unsigned CS_SEL_W   = 3,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned GAP_HALF   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CS_SEL_W-1:0]   cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_CS-1:0]     cs_n,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_HALF + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_HALF - 1);

    logic [2:0]            state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  half_done;
    logic                  cs_sel_ok;
    logic [EDGE_W-1:0]     edge_nxt;

    assign half_done = (cnt_q == div_q);
    assign cs_sel_ok = (32'(cs_sel) < NUM_CS);
    assign edge_nxt  = edge_q + EDGE_W'(1);

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        gap_d      = gap_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = half_done ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                cnt_d  = '0;
                if (start) begin
                    if (cs_sel_ok) begin
                        state_d    = S_LEAD;
                        cpol_d     = cpol;
                        cpha_d     = cpha;
                        div_d      = clk_div;
                        edge_d     = '0;
                        rx_shift_d = '0;
                        cs_n_d     = ~(NUM_CS'(1) << cs_sel);
                        busy_d     = 1'b1;
                        // cpha=0 presents the MSB together with the cs_n fall
                        if (cpha) begin
                            tx_shift_d = tx_data;
                            mosi_d     = 1'b0;
                        end else begin
                            tx_shift_d = tx_data << 1;
                            mosi_d     = tx_data[DATA_WIDTH-1];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LEAD, S_SHIFT: begin
                if (half_done) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    // Odd edges lead; shift-out edge parity matches cpha, the other edge samples
                    if (edge_nxt[0] == cpha_q) begin
                        if (edge_nxt != LAST_EDGE) begin
                            mosi_d     = tx_shift_q[DATA_WIDTH-1];
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end else begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                    end
                    if (state_q == S_LEAD) begin
                        state_d = S_SHIFT;
                    end else if (edge_nxt == LAST_EDGE) begin
                        state_d = S_TRAIL;
                    end
                end
            end

            S_TRAIL: begin
                if (half_done) begin
                    state_d    = S_GAP;
                    gap_d      = '0;
                    cs_n_d     = '1;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    mosi_d     = 1'b0;
                end
            end

            S_GAP: begin
                if (half_done) begin
                    if (gap_q == LAST_GAP) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            gap_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            gap_q      <= gap_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: stimulus queues expected frames, a negedge monitor
// with a built-in SPI slave model checks timing, mosi/miso words and chip selects.
module tb_spi_master_param;

    localparam int unsigned DW   = 8;
    localparam int unsigned NCS  = 4;
    localparam int unsigned CSW  = 3;
    localparam int unsigned DIVW = 8;
    localparam int unsigned GAP  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [DW-1:0]   tx_data;
    logic [CSW-1:0]  cs_sel;
    logic            cpol;
    logic            cpha;
    logic [DIVW-1:0] clk_div;
    logic            miso;
    logic            sclk;
    logic            mosi;
    logic [NCS-1:0]  cs_n;
    logic [DW-1:0]   rx_data;
    logic            rx_valid;
    logic            busy;
    logic            err;

    spi_master_param #(
        .DATA_WIDTH(DW), .NUM_CS(NCS), .CS_SEL_W(CSW), .DIV_WIDTH(DIVW), .GAP_HALF(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .miso(miso), .sclk(sclk), .mosi(mosi),
        .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned    a;        // cycle count at which cs_n must fall
        int unsigned    h;        // half-period in clk cycles
        logic [NCS-1:0] csn;
        logic [DW-1:0]  rx_exp;
        logic [DW-1:0]  mosi_exp;
        logic [DW-1:0]  sw;       // word the slave shifts out
        logic           loop;
        logic           pol;
        logic           pha;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Slave model and monitor state
    logic          s_on = 1'b0, s_loop = 1'b0, s_pol = 1'b0, s_pha = 1'b0, sl_miso = 1'b0;
    logic [DW-1:0] s_tx = '0, s_rx = '0;
    logic          prev_act = 1'b0, prev_sclk = 1'b0, prev_busy = 1'b0, act, lead;
    int unsigned   tog_cnt = 0, tbad = 0;
    frame_t        cur;

    assign miso = s_loop ? mosi : sl_miso;

    always @(negedge clk) begin
        act = (cs_n != {NCS{1'b1}});
        if (act && !prev_act && !abort) begin
            if (exp_q.size() == 0) begin
                flag("csn_unexpected");
            end else begin
                cur     = exp_q[0];
                s_on    = 1'b1;
                s_pol   = cur.pol;
                s_pha   = cur.pha;
                s_tx    = cur.sw;
                s_rx    = '0;
                s_loop  = cur.loop;
                tog_cnt = 0;
                tbad    = 0;
                if (!s_pha) begin
                    sl_miso = s_tx[DW-1];
                    s_tx    = s_tx << 1;
                end
                check("csn_fall_cycle", cyc, cur.a);
                check("csn_pattern", 32'(cs_n), 32'(cur.csn));
                check("sclk_idle", 32'(sclk), 32'(cur.pol));
                check("busy_rise", 32'(busy), 32'd1);
            end
        end else if (act && prev_act && s_on) begin
            if (cs_n != cur.csn) tbad++;
            if (sclk != prev_sclk) begin
                tog_cnt++;
                if (cyc != cur.a + tog_cnt * cur.h) tbad++;
                lead = (sclk != s_pol);
                if (lead == !s_pha) begin
                    s_rx = {s_rx[DW-2:0], mosi};
                end else begin
                    sl_miso = s_tx[DW-1];
                    s_tx    = s_tx << 1;
                end
            end
        end else if (!act && prev_act && s_on) begin
            s_on   = 1'b0;
            s_loop = 1'b0;
            check("toggle_count", tog_cnt, 2 * DW);
            check("edge_timing_errors", tbad, 32'd0);
            check("mosi_word", 32'(s_rx), 32'(cur.mosi_exp));
            check("mosi_idle", 32'(mosi), 32'd0);
        end
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                flag("rx_valid_unexpected");
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_q[0].rx_exp));
                check("rx_valid_cycle", cyc, exp_q[0].a + (2 * DW + 1) * exp_q[0].h);
            end
        end
        if (!busy && prev_busy && !abort && exp_q.size() > 0) begin
            check("busy_fall_cycle", cyc, exp_q[0].a + (2 * DW + 1 + GAP) * exp_q[0].h);
            void'(exp_q.pop_front());
        end
        prev_act  = act;
        prev_sclk = sclk;
        prev_busy = busy;
    end

    function automatic frame_t mk(input int unsigned a, input logic [DIVW-1:0] div,
                                  input logic [CSW-1:0] sel, input logic [DW-1:0] tx,
                                  input logic [DW-1:0] sw, input logic loop,
                                  input logic pol, input logic pha);
        frame_t f;
        f.a        = a;
        f.h        = 32'(div) + 1;
        f.csn      = ~(NCS'(1) << sel);
        f.rx_exp   = loop ? tx : sw;
        f.mosi_exp = tx;
        f.sw       = sw;
        f.loop     = loop;
        f.pol      = pol;
        f.pha      = pha;
        return f;
    endfunction

    task automatic start_frame(input logic [DW-1:0] tx, input logic [CSW-1:0] sel,
                               input logic pol, input logic pha, input logic [DIVW-1:0] div,
                               input logic [DW-1:0] sw, input logic loop,
                               output int unsigned a);
        @(negedge clk);
        tx_data = tx;
        cs_sel  = sel;
        cpol    = pol;
        cpha    = pha;
        clk_div = div;
        start   = 1'b1;
        a       = cyc + 1;
        exp_q.push_back(mk(a, div, sel, tx, sw, loop, pol, pha));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            flag("idle_timeout");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [DW-1:0] tx, input logic [CSW-1:0] sel,
                             input logic pol, input logic pha, input logic [DIVW-1:0] div,
                             input logic [DW-1:0] sw, input logic loop);
        int unsigned a;
        start_frame(tx, sel, pol, pha, div, sw, loop, a);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CSW-1:0] bad_sel [2];
        int unsigned    a1, a2, ab_a;
        bad_sel = '{3'd5, 3'd4};
        reset   = 1'b1;
        start   = 1'b0;
        tx_data = '0;
        cs_sel  = '0;
        cpol    = 1'b0;
        cpha    = 1'b0;
        clk_div = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({sclk, mosi, cs_n, rx_valid, busy, err}), 32'({2'b00, 4'hF, 3'b000}));
        check("reset_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0 loopback, mode 3 slow, modes 1 and 2 against a slave returning 0x5A
        run_frame(8'hA5, 3'd0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
        run_frame(8'h3C, 3'd1, 1'b1, 1'b1, 8'd4, 8'hC3, 1'b0);
        run_frame(8'h96, 3'd2, 1'b0, 1'b1, 8'd1, 8'h5A, 1'b0);
        run_frame(8'h69, 3'd3, 1'b1, 1'b0, 8'd1, 8'h5A, 1'b0);

        // Out-of-range chip selects are rejected with a single err pulse
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cs_sel = bad_sel[i];
            cpol   = 1'b0;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("err_pulse", 32'({err, busy, cs_n}), 32'({1'b1, 1'b0, 4'hF}));
            @(negedge clk);
            check("err_clear", 32'({err, busy, cs_n}), 32'({1'b0, 1'b0, 4'hF}));
        end

        // Held start: back-to-back frames; mid-frame input changes only affect the next frame
        start_frame(8'h81, 3'd1, 1'b0, 1'b0, 8'd0, 8'h33, 1'b0, a1);
        repeat (6) @(negedge clk);
        tx_data = 8'h7E;
        cs_sel  = 3'd2;
        a2      = a1 + 1 + (2 * DW + 1 + GAP);
        exp_q.push_back(mk(a2, 8'd0, 3'd2, 8'h7E, 8'hCC, 1'b0, 1'b0, 1'b0));
        while (cyc < a2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset after the fifth toggle aborts the frame without rx_valid
        abort = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        cs_sel  = 3'd0;
        cpol    = 1'b0;
        cpha    = 1'b0;
        clk_div = 8'd1;
        start   = 1'b1;
        ab_a    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < ab_a + 10) @(negedge clk);
        check("abort_pre_reset", 32'({sclk, mosi, busy}), 32'({1'b1, 1'b1, 1'b1}));
        reset = 1'b1;
        #1;
        check("abort_outputs", 32'({sclk, mosi, cs_n, rx_valid, busy, err}), 32'({2'b00, 4'hF, 3'b000}));
        check("abort_rx_data", 32'(rx_data), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        abort = 1'b0;

        run_frame(8'h5A, 3'd3, 1'b0, 1'b0, 8'd2, 8'h96, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised, full-duplex SPI master; next generation of the team's fixed 8-bit SPI block.
- Adds configurable frame width, all four SPI modes (CPOL/CPHA), a runtime clock divider and multiple one-hot chip selects.
- Sits between the register/UART command layer and external SPI peripherals (ADCs, DACs); one frame per start request.

Parameters:
DATA_WIDTH, 8, bits per frame (2..32), shifted MSB first
NUM_CS, 1, number of chip-select lines (1..8)
CS_SEL_W, 3, width of cs_sel; must satisfy 2**CS_SEL_W >= NUM_CS
DIV_WIDTH, 8, width of clk_div
GAP_HALF, 4, inter-frame idle time in sclk half-periods (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  frame request, sampled only in IDLE
tx_data  in  DATA_WIDTH  frame to transmit, latched on accept
cs_sel  in  CS_SEL_W  target slave index, latched on accept
cpol  in  1  clock polarity, latched on accept
cpha  in  1  clock phase, latched on accept
clk_div  in  DIV_WIDTH  half-period = clk_div+1 clk cycles, latched on accept
miso  in  1  serial data from slave
sclk  out  1  SPI clock
mosi  out  1  serial data to slave
cs_n  out  NUM_CS  active-low chip selects, at most one low
rx_data  out  DATA_WIDTH  last received frame, held until next frame completes
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  high from the cycle after accept until return to IDLE
err  out  1  one-cycle pulse: start rejected because cs_sel >= NUM_CS

Behaviour:
- Reset values: sclk=0, mosi=0, cs_n=all 1, rx_data=0, rx_valid=0, busy=0, err=0, state=IDLE. Reset mid-frame aborts immediately; no rx_valid is generated.
- H = latched clk_div+1. Half-period counter counts 0..H-1; clk_div=0 gives sclk = clk/2.
- States: IDLE, LEAD, SHIFT, TRAIL, GAP.
- IDLE: sclk follows live cpol (registered). A start with cs_sel < NUM_CS is accepted: config and tx_data are latched. In the next cycle cs_n[cs_sel]=0, busy=1, state=LEAD. A start with cs_sel >= NUM_CS gives err=1 for one cycle and the block stays in IDLE.
- LEAD: lasts H cycles with sclk at idle level. If cpha=0, mosi = tx_data MSB from the cs_n falling cycle.
- SHIFT: 2*DATA_WIDTH sclk toggles spaced H cycles apart; the first toggle occurs H cycles after cs_n falls. Odd toggles are leading edges, even toggles are trailing edges.
  - cpha=0: sample miso on leading edges; update mosi on trailing edges, except the final trailing edge.
  - cpha=1: update mosi on leading edges (MSB on the first); sample miso on trailing edges.
- Sampling: sampled bits shift into rx_shift LSB-first-in, so the first bit ends up as the MSB. Sampling and the sclk toggle happen in the same clk cycle, using the miso value present before the edge.
- TRAIL: H cycles after the last toggle with sclk at idle level. On exit: cs_n=all 1, rx_data<=rx_shift, rx_valid=1 for one cycle, mosi<=0, state=GAP.
- GAP: GAP_HALF*H cycles with cs_n high. busy drops and the state returns to IDLE after the last gap cycle; start is sampled again from that IDLE cycle.
- Timing: with accept at cycle 0, cs_n falls at cycle 1, the toggles are at cycles 1+k*H for k=1..2*DATA_WIDTH, rx_valid is at 1+(2*DATA_WIDTH+1)*H, and busy falls at 1+(2*DATA_WIDTH+1+GAP_HALF)*H.
- Input changes: changes to start, tx_data, cpol, cpha, clk_div or cs_sel while busy have no effect on the current frame.
- Held start: start held high produces back-to-back frames separated by exactly the GAP.

Test Plan:
- Mode 0, DATA_WIDTH=8, clk_div=0, tx_data=0xA5, miso looped to mosi -> cs_n low at cycle 1; 16 toggles at cycles 2..17; rx_data=0xA5 with rx_valid at cycle 18; sclk idles 0.
- Mode 3, clk_div=4, tx_data=0x3C, slave model returns 0xC3 -> sclk idles 1 with a half-period of 5 cycles; mosi bits are 0,0,1,1,1,1,0,0 on leading edges; rx_data=0xC3 at cycle 86.
- Modes 1 and 2 at clk_div=1 with a slave model shifting on the matching edges -> mosi and miso bits are captured on the correct edges; 0x5A is received in each mode.
- NUM_CS=4: cs_sel=2 -> only cs_n[2] goes low. cs_sel=5 with CS_SEL_W=3 -> err pulse, no cs_n activity, busy stays 0.
- Start held high for two frames -> the second cs_n fall occurs GAP_HALF*H+1 cycles after the first cs_n rise. tx_data changed mid-frame does not corrupt the first frame's mosi.
- reset asserted after the 5th toggle -> all outputs at reset values within that cycle, no rx_valid; a new start after reset release completes normally.
